uart_rx: RTL and testbench

//  Receives 8N1 UART frames from an external device on serial line Rx and delivers each byte as a parallel word.

---
 rtl/uart_rx.sv | 78 +++++++
 tb/tb_uart_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a held data_ready flag, overrun and framing error pulses
module uart_rx #(
  parameter int CLKS_PER_BIT = 428,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       data_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       ledRx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          rx_m, rx_s;
  logic          stop_smp, accept;
  assign stop_smp = state == STOP && clk_cnt == BIT_END;
  assign accept   = stop_smp && rx_s;
  assign ledRx    = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= Rx;
      rx_s       <= rx_m;
      valid      <= accept;
      frame_err  <= stop_smp && !rx_s;
      // a read coinciding with a new byte consumes the old byte, so no overrun and the flag stays set
      overrun    <= accept && data_ready && !rd;
      data_ready <= accept || (data_ready && !rd);
      if (accept) data <= shift;
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
        START: if (clk_cnt == HALF_END) begin
          clk_cnt <= '0;
          state   <= rx_s ? IDLE : DATA;
        end else clk_cnt <= clk_cnt + CW'(1);
        DATA: if (clk_cnt == BIT_END) begin
          clk_cnt        <= '0;
          shift[bit_cnt] <= rx_s;
          bit_cnt        <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= STOP;
        end else clk_cnt <= clk_cnt + CW'(1);
        // leave at stop-bit centre so a following start edge is not missed
        STOP: if (clk_cnt == BIT_END) begin
          clk_cnt <= '0;
          state   <= rx_s ? IDLE : BRK;
        end else clk_cnt <= clk_cnt + CW'(1);
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame vectors plus glitch, break and mid-frame reset sequences
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = 8;
  localparam int LAT = 2 + H + 9 * C + 1;
  logic clk = 0, rst = 1, Rx = 1, rd = 0;
  logic [7:0] data;
  logic valid, data_ready, overrun, frame_err, ledRx;
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .rd(rd), .data(data), .valid(valid),
    .data_ready(data_ready), .overrun(overrun), .frame_err(frame_err), .ledRx(ledRx)
  );
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  int n_valid = 0, n_fe = 0, n_ovr = 0, n_both = 0, t_start = 0, t_valid = 0;
  logic [7:0] last_data = 0;
  logic ready_on_valid = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      last_data <= data;
      ready_on_valid <= data_ready;
      t_valid <= cyc;
    end
    if (overrun) n_ovr <= n_ovr + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (valid && frame_err) n_both <= n_both + 1;
  end
  typedef struct {
    logic [7:0] b;
    int         rd_mode;
    int         ovr_inc;
    logic       ready_end;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // rd_mode 1: rd sampled on the edge that loads the byte; 2: rd the cycle after valid
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_mode);
    Rx = 0;
    t_start = cyc;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      tick(C);
    end
    Rx = stop;
    tick(10);
    if (rd_mode == 1) rd = 1;
    tick(1);
    rd = 0;
    tick(1);
    if (rd_mode == 2) rd = 1;
    tick(1);
    rd = 0;
    tick(C - 13);
  endtask
  initial begin
    int v0, f0, o0;
    vecs[0] = '{8'hA5, 2, 0, 1'b0};
    vecs[1] = '{8'h00, 2, 0, 1'b0};
    vecs[2] = '{8'hFF, 2, 0, 1'b0};
    vecs[3] = '{8'h11, 0, 0, 1'b1};
    vecs[4] = '{8'h22, 0, 1, 1'b1};
    vecs[5] = '{8'h33, 1, 0, 1'b1};
    tick(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_led", ledRx, 0);
    rst = 0;
    tick(4);
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; f0 = n_fe; o0 = n_ovr;
      send_frame(vecs[i].b, 1'b1, vecs[i].rd_mode);
      chk($sformatf("v%0d_data", i), data, vecs[i].b);
      chk($sformatf("v%0d_strobed", i), last_data, vecs[i].b);
      chk($sformatf("v%0d_valid", i), n_valid - v0, 1);
      chk($sformatf("v%0d_fe", i), n_fe - f0, 0);
      chk($sformatf("v%0d_ovr", i), n_ovr - o0, vecs[i].ovr_inc);
      chk($sformatf("v%0d_ready_v", i), ready_on_valid, 1);
      chk($sformatf("v%0d_ready", i), data_ready, vecs[i].ready_end);
      chk($sformatf("v%0d_lat", i), t_valid - t_start, LAT);
    end
    tick(5);
    rd = 1; tick(1); rd = 0; tick(1);
    chk("rd_clear", data_ready, 0);
    rd = 1; tick(1); rd = 0; tick(1);
    chk("rd_idle", data_ready, 0);
    v0 = n_valid; f0 = n_fe;
    Rx = 0; tick(5); Rx = 1; tick(3);
    chk("glitch_start", ledRx, 1);
    tick(20);
    chk("glitch_idle", ledRx, 0);
    chk("glitch_valid", n_valid - v0, 0);
    chk("glitch_fe", n_fe - f0, 0);
    send_frame(8'h3C, 1'b0, 0);
    tick(40);
    chk("brk_fe", n_fe - f0, 1);
    chk("brk_valid", n_valid - v0, 0);
    chk("brk_data", data, 8'h33);
    chk("brk_led", ledRx, 1);
    Rx = 1;
    tick(30);
    chk("brk_idle", ledRx, 0);
    chk("brk_fe_after", n_fe - f0, 1);
    chk("brk_valid_after", n_valid - v0, 0);
    Rx = 0; tick(C);
    Rx = 0; tick(C);
    Rx = 1; tick(C);
    Rx = 0; tick(C);
    Rx = 1; tick(C);
    Rx = 1; tick(8);
    chk("mid_led", ledRx, 1);
    #2 rst = 1;
    #1;
    chk("mrst_data", data, 8'h00);
    chk("mrst_valid", valid, 0);
    chk("mrst_ready", data_ready, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_fe", frame_err, 0);
    chk("mrst_led", ledRx, 0);
    Rx = 1;
    tick(3);
    rst = 0;
    tick(5);
    chk("post_led", ledRx, 0);
    v0 = n_valid;
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        tick(80);
        chk("frame_led", ledRx, 1);
      end
    join
    chk("post_data", data, 8'h5A);
    chk("post_valid", n_valid - v0, 1);
    chk("post_ready", data_ready, 1);
    chk("post_idle", ledRx, 0);
    chk("valid_fe_excl", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
